fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage plus F/D pipeline register of the pipelined ARM core. It sits directly upstream of the decode stage and consumes the hazard unit's StallF, StallD and FlushD outputs. It owns the PC register, next-PC selection (sequential, EX-stage branch redirect, WB-stage PC write) and the InstrD/PCPlus4D/PCPlus8D pipeline register. It also provides saturating fetch/stall/flush performance counters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
StallF  input  1  hold PC register (from hazard unit)
StallD  input  1  hold F/D register (from hazard unit)
FlushD  input  1  clear F/D register to bubble (from hazard unit)
BranchTakenE  input  1  taken branch resolved in EX
BranchTargetE  input  32  branch target (ALUResultE)
PCSrcW  input  1  instruction in WB writes R15
ResultW  input  32  WB result, used as new PC when PCSrcW
PCF  output  32  current fetch address to instruction memory
InstrF  input  32  instruction memory read data for PCF (combinational)
InstrD  output  32  instruction in decode
PCPlus4D  output  32  address of InstrD + 4 (BL link value)
PCPlus8D  output  32  address of InstrD + 8 (R15 read value)
ValidD  output  1  InstrD is a real instruction, not a bubble
FetchCount  output  CNT_WIDTH  instructions accepted into D
StallCount  output  CNT_WIDTH  cycles PC was held by StallF
FlushCount  output  CNT_WIDTH  cycles FlushD was asserted

Behaviour:
- Reset (synchronous, highest priority): PCF=RESET_PC; InstrD=0, PCPlus4D=0, PCPlus8D=0, ValidD=0; all counters=0.
- Next-PC priority, evaluated each cycle when not in reset:
  1. BranchTakenE -> PCF <= {BranchTargetE[31:2],2'b00}
  2. else PCSrcW -> PCF <= {ResultW[31:2],2'b00}
  3. else StallF -> PCF holds
  4. else PCF <= PCF+4; wraps from 32'hFFFF_FFFC to 32'h0000_0000
- Redirects (1, 2) override StallF. A redirect is never lost to a concurrent stall.
- Address bits [1:0] of any redirect target are forced to 0. PCF[1:0] is always 2'b00.
- F/D register priority:
  1. FlushD -> InstrD=0, PCPlus4D=0, PCPlus8D=0, ValidD=0. FlushD wins over StallD when both are asserted.
  2. else StallD -> all D outputs hold, including ValidD.
  3. else InstrD<=InstrF, PCPlus4D<=PCF+4, PCPlus8D<=PCF+8, ValidD<=1.
- PCPlus4D/PCPlus8D use modulo-2^32 arithmetic; no carry out.
- Latency: an instruction at PCF in cycle n appears on InstrD in cycle n+1 if not flushed or stalled.
- Counter updates, all saturating at all-ones and never wrapping:
  - FetchCount += 1 on cycles that take F/D priority 3.
  - StallCount += 1 when StallF=1 and neither BranchTakenE nor PCSrcW is asserted.
  - FlushCount += 1 when FlushD=1.
- Reset asserted mid-operation clears everything on that edge regardless of other inputs. The first fetch after reset deassertion is from RESET_PC.
- No internal combinational path from inputs to PCF. PCF is a pure register output.

Test Plan:
- Reset then free-run, InstrF=32'hE000_0000+PCF: PCF steps 0,4,8,...; InstrD lags by one cycle; PCPlus8D=8 when InstrD=32'hE000_0000; ValidD=1 from the 2nd cycle; FetchCount=N after N loads.
- StallF=StallD=1 for 3 cycles at PCF=0x10: PCF holds at 0x10, InstrD holds, StallCount=3, FetchCount unchanged; after release, PCF=0x14 on the next edge.
- BranchTakenE=1 with BranchTargetE=0x0000_0103 while StallF=1 and FlushD=1: PCF=0x100 next cycle, ValidD=0, InstrD=0, FlushCount+1, StallCount unchanged.
- PCSrcW=1 with ResultW=0x200 and BranchTakenE=1 with target 0x300 in the same cycle: PCF=0x300. Repeat with PCSrcW alone: PCF=0x200.
- FlushD=1 and StallD=1 together: D register becomes a bubble (ValidD=0). PCF=0xFFFF_FFFC free-run: next PCF=0x0 and PCPlus8D for that instruction=0x4.
- Force FetchCount to all-ones (CNT_WIDTH=4, 16+ loads): counter sticks at 4'hF. Assert reset mid-stream: all counters 0 and PCF=RESET_PC on the same edge.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard controls, redirects, instruction memory port,
// F/D register outputs and performance counters.
interface fetch_stage_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 StallF;
  logic                 StallD;
  logic                 FlushD;
  logic                 BranchTakenE;
  logic [31:0]          BranchTargetE;
  logic                 PCSrcW;
  logic [31:0]          ResultW;
  logic [31:0]          PCF;
  logic [31:0]          InstrF;
  logic [31:0]          InstrD;
  logic [31:0]          PCPlus4D;
  logic [31:0]          PCPlus8D;
  logic                 ValidD;
  logic [CNT_WIDTH-1:0] FetchCount;
  logic [CNT_WIDTH-1:0] StallCount;
  logic [CNT_WIDTH-1:0] FlushCount;

  // The fetch stage itself is the master of this bus.
  modport master (
    input  StallF, StallD, FlushD, BranchTakenE, BranchTargetE,
    input  PCSrcW, ResultW, InstrF,
    output PCF, InstrD, PCPlus4D, PCPlus8D, ValidD,
    output FetchCount, StallCount, FlushCount
  );

  modport slave (
    output StallF, StallD, FlushD, BranchTakenE, BranchTargetE,
    output PCSrcW, ResultW, InstrF,
    input  PCF, InstrD, PCPlus4D, PCPlus8D, ValidD,
    input  FetchCount, StallCount, FlushCount
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, F/D pipeline
// register and saturating fetch/stall/flush counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [31:0]          pc_q, pc_d;
  logic [31:0]          instr_q, instr_d;
  logic [31:0]          pc4_q, pc4_d;
  logic [31:0]          pc8_q, pc8_d;
  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic redirect;
  logic fd_load;

  // Redirects beat StallF so a resolved branch or R15 write is never dropped.
  always_comb begin
    redirect = bus.BranchTakenE | bus.PCSrcW;
    pc_d     = pc_q + 32'd4;
    if (bus.BranchTakenE) begin
      pc_d = {bus.BranchTargetE[31:2], 2'b00};
    end else if (bus.PCSrcW) begin
      pc_d = {bus.ResultW[31:2], 2'b00};
    end else if (bus.StallF) begin
      pc_d = pc_q;
    end
  end

  // FlushD dominates StallD; a flushed slot becomes an all-zero bubble.
  always_comb begin
    fd_load = !bus.FlushD && !bus.StallD;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    pc8_d   = pc8_q;
    valid_d = valid_q;
    if (bus.FlushD) begin
      instr_d = 32'd0;
      pc4_d   = 32'd0;
      pc8_d   = 32'd0;
      valid_d = 1'b0;
    end else if (fd_load) begin
      instr_d = bus.InstrF;
      pc4_d   = pc_q + 32'd4;
      pc8_d   = pc_q + 32'd8;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    fetch_cnt_d = fd_load ? sat_inc(fetch_cnt_q) : fetch_cnt_q;
    stall_cnt_d = (bus.StallF && !redirect) ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = bus.FlushD ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      instr_q     <= 32'd0;
      pc4_q       <= 32'd0;
      pc8_q       <= 32'd0;
      valid_q     <= 1'b0;
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      pc8_q       <= pc8_d;
      valid_q     <= valid_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.PCF        = pc_q;
  assign bus.InstrD     = instr_q;
  assign bus.PCPlus4D   = pc4_q;
  assign bus.PCPlus8D   = pc8_q;
  assign bus.ValidD     = valid_q;
  assign bus.FetchCount = fetch_cnt_q;
  assign bus.StallCount = stall_cnt_q;
  assign bus.FlushCount = flush_cnt_q;

endmodule
